param_issue_buffer: RTL and testbench

- Generalised, parametrised issue buffer that sits between the reservation-station dispatch lanes and one class of functional units (ALU, MUL, load or store).
- Holds up to DEPTH decoded-and-read packets in age order.
- Each cycle it issues the oldest ready entries to up to N_OUT non-busy FU ports.
- Supports branch-mask squash, multi-lane mask-bit clearing, a global stall, and a registered free-slot credit.

---
 rtl/param_issue_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_param_issue_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_issue_buffer.sv
// Issue buffer between reservation-station dispatch lanes and one class of
// functional units. It holds up to DEPTH packets in age order in a collapsing
// queue, with index 0 the oldest. Each cycle the oldest surviving entries go
// to the non-busy FU ports. Branch-mask squash and mask-bit clearing are
// applied combinationally before selection.
//
// Handshake: out_valid[j] means port j takes a packet this cycle. The
// fu_busy[j] input is the inverse of a ready, and the buffer never presents
// on a busy port. Upstream may dispatch at most `avail` packets per cycle.
// Packets beyond the free space are dropped, and overflow_err then latches.
module param_issue_buffer #(
    parameter int DEPTH     = 8,
    parameter int N_IN      = 3,
    parameter int N_OUT     = 2,
    parameter int PAYLOAD_W = 128,
    parameter int BMASK_W   = 4,
    parameter int N_CLR     = 2,
    parameter int BW        = (BMASK_W > 1) ? $clog2(BMASK_W) : 1,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_IN-1:0]              in_valid,
    input  logic [N_IN*PAYLOAD_W-1:0]    in_payload,
    input  logic [N_IN*BMASK_W-1:0]      in_bmask,
    input  logic [N_OUT-1:0]             fu_busy,
    input  logic                         stall,
    input  logic                         squash_en,
    input  logic [BW-1:0]                squash_bit,
    input  logic [N_CLR-1:0]             clr_en,
    input  logic [N_CLR*BW-1:0]          clr_bit,
    output logic [N_OUT-1:0]             out_valid,
    output logic [N_OUT*PAYLOAD_W-1:0]   out_payload,
    output logic [N_OUT*BMASK_W-1:0]     out_bmask,
    output logic [CW-1:0]                avail,
    output logic [CW-1:0]                occupancy,
    output logic                         overflow_err
);

    // The rank width covers every stored entry plus every incoming lane.
    localparam int RW = $clog2(DEPTH + N_IN + 1);
    localparam logic [RW-1:0] DEPTH_R = RW'(DEPTH);
    localparam logic [RW-1:0] N_IN_R = RW'(N_IN);
    localparam int AVAIL_RST = (DEPTH < N_IN) ? DEPTH : N_IN;

    logic                 valid_q   [DEPTH];
    logic                 valid_d   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [BMASK_W-1:0]   bmask_q   [DEPTH];
    logic [BMASK_W-1:0]   bmask_d   [DEPTH];
    logic [CW-1:0]        avail_q, avail_d;
    logic [CW-1:0]        occ_q, occ_d;
    logic                 overflow_q, overflow_d;

    logic [BMASK_W-1:0]   clr_vec;
    logic [DEPTH-1:0]     alive;
    logic [BMASK_W-1:0]   mask_c    [DEPTH];
    logic [N_IN-1:0]      lane_alive;
    logic [BMASK_W-1:0]   lane_mask [N_IN];
    logic [PAYLOAD_W-1:0] lane_pay  [N_IN];
    logic [DEPTH-1:0]     issued;
    logic [DEPTH-1:0]     keep;
    logic [RW-1:0]        srank     [DEPTH];
    logic [RW-1:0]        lrank     [N_IN];
    logic [RW-1:0]        total;
    logic [RW-1:0]        free_cnt;
    logic                 drop;

    // A packet dies when squash is active and its original mask has the
    // squash bit set. A clear of the same bit in this cycle does not save it.
    function automatic logic killed(input logic [BMASK_W-1:0] m,
                                    input logic en,
                                    input logic [BW-1:0] b);
        return en && m[b];
    endfunction

    // Merge all clear lanes into one bit vector that is removed from every mask.
    always_comb begin
        clr_vec = '0;
        for (int k = 0; k < N_CLR; k++) begin
            if (clr_en[k]) clr_vec[clr_bit[k*BW +: BW]] = 1'b1;
        end
    end

    // Work out survivors and cleared masks for stored entries and incoming lanes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            alive[i]  = valid_q[i] && !killed(bmask_q[i], squash_en, squash_bit);
            mask_c[i] = bmask_q[i] & ~clr_vec;
        end
        for (int l = 0; l < N_IN; l++) begin
            lane_pay[l]   = in_payload[l*PAYLOAD_W +: PAYLOAD_W];
            lane_mask[l]  = in_bmask[l*BMASK_W +: BMASK_W] & ~clr_vec;
            lane_alive[l] = in_valid[l] &&
                            !killed(in_bmask[l*BMASK_W +: BMASK_W], squash_en, squash_bit);
        end
    end

    // Oldest-first selection: each survivor takes the lowest free, non-busy port.
    always_comb begin
        logic [N_OUT-1:0] port_taken;
        logic             placed;
        port_taken  = '0;
        placed      = 1'b0;
        issued      = '0;
        out_valid   = '0;
        out_payload = '0;
        out_bmask   = '0;
        if (!stall && !reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                placed = 1'b0;
                if (alive[i]) begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (!placed && !port_taken[j] && !fu_busy[j]) begin
                            placed                               = 1'b1;
                            port_taken[j]                        = 1'b1;
                            issued[i]                            = 1'b1;
                            out_valid[j]                         = 1'b1;
                            out_payload[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
                            out_bmask[j*BMASK_W +: BMASK_W]       = mask_c[i];
                        end
                    end
                end
            end
        end
    end

    // Compaction: kept entries get destinations by rank, and surviving lanes
    // follow in lane order. Ranks at or beyond DEPTH are dropped.
    always_comb begin
        total = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keep[i]  = alive[i] && !issued[i];
            srank[i] = total;
            if (keep[i]) total = total + 1'b1;
        end
        for (int l = 0; l < N_IN; l++) begin
            lrank[l] = total;
            if (lane_alive[l]) total = total + 1'b1;
        end

        drop = 1'b0;
        for (int l = 0; l < N_IN; l++) begin
            if (lane_alive[l] && (lrank[l] >= DEPTH_R)) drop = 1'b1;
        end

        for (int d = 0; d < DEPTH; d++) begin
            valid_d[d]   = 1'b0;
            payload_d[d] = '0;
            bmask_d[d]   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && (srank[i] == RW'(d))) begin
                    valid_d[d]   = 1'b1;
                    payload_d[d] = payload_q[i];
                    bmask_d[d]   = mask_c[i];
                end
            end
            for (int l = 0; l < N_IN; l++) begin
                if (lane_alive[l] && (lrank[l] == RW'(d))) begin
                    valid_d[d]   = 1'b1;
                    payload_d[d] = lane_pay[l];
                    bmask_d[d]   = lane_mask[l];
                end
            end
        end

        if (total > DEPTH_R) total = DEPTH_R;
        free_cnt   = DEPTH_R - total;
        occ_d      = CW'(total);
        avail_d    = (free_cnt > N_IN_R) ? CW'(N_IN) : CW'(free_cnt);
        overflow_d = overflow_q | drop;
    end

    // State register. Reset discards all contents, whatever the other inputs are.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= 1'b0;
                payload_q[i] <= '0;
                bmask_q[i]   <= '0;
            end
            avail_q    <= CW'(AVAIL_RST);
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]   <= valid_d[i];
                payload_q[i] <= payload_d[i];
                bmask_q[i]   <= bmask_d[i];
            end
            avail_q    <= avail_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    assign avail        = avail_q;
    assign occupancy    = occ_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_param_issue_buffer.sv
// Bench for param_issue_buffer. A queue-based reference model predicts each
// cycle's issues and the registered counters. A negedge monitor compares
// them against the DUT.
module tb_param_issue_buffer;

    localparam int DEPTH = 8;
    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int PW    = 128;
    localparam int BMW   = 4;
    localparam int N_CLR = 2;
    localparam int BW    = 2;
    localparam int CW    = 4;
    localparam int W     = 8 + PW + BMW;
    localparam int SW    = N_OUT + 2*CW + 1;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                   reset = 1'b1;
    logic [N_IN-1:0]        in_valid = '0;
    logic [N_IN*PW-1:0]     in_payload = '0;
    logic [N_IN*BMW-1:0]    in_bmask = '0;
    logic [N_OUT-1:0]       fu_busy = '0;
    logic                   stall = 1'b0;
    logic                   squash_en = 1'b0;
    logic [BW-1:0]          squash_bit = '0;
    logic [N_CLR-1:0]       clr_en = '0;
    logic [N_CLR*BW-1:0]    clr_bit = '0;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT*PW-1:0]    out_payload;
    logic [N_OUT*BMW-1:0]   out_bmask;
    logic [CW-1:0]          avail;
    logic [CW-1:0]          occupancy;
    logic                   overflow_err;

    param_issue_buffer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_payload(in_payload), .in_bmask(in_bmask),
        .fu_busy(fu_busy), .stall(stall),
        .squash_en(squash_en), .squash_bit(squash_bit),
        .clr_en(clr_en), .clr_bit(clr_bit),
        .out_valid(out_valid), .out_payload(out_payload), .out_bmask(out_bmask),
        .avail(avail), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    // reference model and scoreboard
    typedef struct packed {
        logic [PW-1:0]  pay;
        logic [BMW-1:0] m;
    } ent_t;

    ent_t           mq[$];
    logic           ovf_m = 1'b0;
    logic [W-1:0]   exp_q[$];
    logic [SW-1:0]  st_q[$];
    int             total = 0;
    int             bad = 0;
    logic           push_en = 1'b0;
    logic           mon_en = 1'b0;

    // staged stimulus, applied just after the next rising edge
    logic            st_rst;
    logic [N_IN-1:0] st_v;
    logic [PW-1:0]   st_pay [N_IN];
    logic [BMW-1:0]  st_m   [N_IN];
    logic [N_OUT-1:0] st_busy;
    logic            st_stall;
    logic            st_sq;
    logic [BW-1:0]   st_sqb;
    logic [N_CLR-1:0] st_clr;
    logic [BW-1:0]   st_clrb [N_CLR];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_avail();
        int f;
        f = DEPTH - mq.size();
        return (f < N_IN) ? f : N_IN;
    endfunction

    function automatic logic [PW-1:0] rpay();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // driver tasks
    task automatic stage_idle();
        st_rst = 1'b0; st_v = '0; st_busy = '0; st_stall = 1'b0;
        st_sq = 1'b0; st_sqb = '0; st_clr = '0;
        for (int l = 0; l < N_IN; l++) begin st_pay[l] = '0; st_m[l] = '0; end
        for (int k = 0; k < N_CLR; k++) st_clrb[k] = '0;
    endtask

    task automatic lane(input int l, input logic [PW-1:0] p, input logic [BMW-1:0] m);
        st_v[l] = 1'b1; st_pay[l] = p; st_m[l] = m;
    endtask

    task automatic cycle();
        logic [BMW-1:0]   clrv;
        logic [N_OUT-1:0] e_v;
        logic [CW-1:0]    e_occ, e_av;
        logic             e_ovf;
        ent_t             s[$];
        ent_t             ne;
        @(posedge clock);
        #1;
        reset = st_rst; in_valid = st_v; fu_busy = st_busy; stall = st_stall;
        squash_en = st_sq; squash_bit = st_sqb; clr_en = st_clr;
        for (int l = 0; l < N_IN; l++) begin
            in_payload[l*PW +: PW] = st_pay[l];
            in_bmask[l*BMW +: BMW] = st_m[l];
        end
        for (int k = 0; k < N_CLR; k++) clr_bit[k*BW +: BW] = st_clrb[k];

        e_occ = CW'(mq.size());
        e_av  = CW'(m_avail());
        e_ovf = ovf_m;
        e_v   = '0;
        if (st_rst) begin
            mq.delete();
            ovf_m = 1'b0;
        end else begin
            clrv = '0;
            for (int k = 0; k < N_CLR; k++) if (st_clr[k]) clrv[st_clrb[k]] = 1'b1;
            foreach (mq[i]) begin
                if (!(st_sq && mq[i].m[st_sqb])) begin
                    ne.pay = mq[i].pay; ne.m = mq[i].m & ~clrv;
                    s.push_back(ne);
                end
            end
            if (!st_stall) begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (!st_busy[j] && s.size() > 0) begin
                        ne = s.pop_front();
                        e_v[j] = 1'b1;
                        if (push_en) exp_q.push_back({8'(j), ne.pay, ne.m});
                    end
                end
            end
            for (int l = 0; l < N_IN; l++) begin
                if (st_v[l] && !(st_sq && st_m[l][st_sqb])) begin
                    if (s.size() < DEPTH) begin
                        ne.pay = st_pay[l]; ne.m = st_m[l] & ~clrv;
                        s.push_back(ne);
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
            mq = s;
        end
        if (push_en) st_q.push_back({e_v, e_occ, e_av, e_ovf});
        mon_en = push_en;
    endtask

    // monitor: pops the expected status and issues for every monitored cycle
    logic [SW-1:0] mon_s;
    logic [W-1:0]  mon_e;
    always @(negedge clock) begin
        if (mon_en) begin
            if (st_q.size() == 0) begin
                total++; bad++;
                $display("FAIL status_queue: got empty expected one entry");
            end else begin
                mon_s = st_q.pop_front();
                chk("occupancy", W'(occupancy), W'(mon_s[2*CW -: CW]));
                chk("avail", W'(avail), W'(mon_s[CW -: CW]));
                chk("overflow_err", W'(overflow_err), W'(mon_s[0]));
                chk("out_valid", W'(out_valid), W'(mon_s[SW-1 -: N_OUT]));
                for (int j = 0; j < N_OUT; j++) begin
                    if (mon_s[SW-N_OUT+j]) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL issue_queue: got empty expected packet on port %0d", j);
                        end else begin
                            mon_e = exp_q.pop_front();
                            chk("issue_port", {8'(j), out_payload[j*PW +: PW], out_bmask[j*BMW +: BMW]}, mon_e);
                        end
                    end else begin
                        chk("idle_port_zero", W'({out_payload[j*PW +: PW], out_bmask[j*BMW +: BMW]}), '0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

    // stimulus and final report
    initial begin
        int n;
        stage_idle();
        st_rst = 1'b1;
        cycle();
        push_en = 1'b1;
        cycle();

        // three lanes, both ports free: A,B then C
        stage_idle();
        lane(0, {4{32'hAAAA_0001}}, 4'b0000);
        lane(1, {4{32'hBBBB_0002}}, 4'b0000);
        lane(2, {4{32'hCCCC_0003}}, 4'b0000);
        cycle();
        stage_idle();
        repeat (3) cycle();

        // fill with ports busy, then overflow by three
        for (int c = 0; c < 3; c++) begin
            stage_idle(); st_busy = 2'b11;
            for (int l = 0; l < ((c == 2) ? 2 : 3); l++) lane(l, rpay(), 4'b0000);
            cycle();
        end
        stage_idle(); st_busy = 2'b11;
        for (int l = 0; l < 3; l++) lane(l, rpay(), 4'b0000);
        cycle();
        stage_idle(); st_busy = 2'b11;
        repeat (2) cycle();
        stage_idle(); st_rst = 1'b1;
        cycle();

        // squash bit 0 during issue: only B survives
        stage_idle(); st_busy = 2'b11;
        lane(0, {4{32'h0A0A_0A0A}}, 4'b0001);
        lane(1, {4{32'h0B0B_0B0B}}, 4'b0010);
        lane(2, {4{32'h0C0C_0C0C}}, 4'b0001);
        cycle();
        stage_idle(); st_sq = 1'b1; st_sqb = 2'd0;
        cycle();
        stage_idle();
        repeat (2) cycle();

        // clear bit 1 while issuing on port 0
        stage_idle(); st_busy = 2'b11;
        for (int l = 0; l < 3; l++) lane(l, rpay(), 4'b0110);
        cycle();
        stage_idle(); st_busy = 2'b10; st_clr = 2'b01; st_clrb[0] = 2'd1;
        cycle();
        stage_idle();
        repeat (2) cycle();

        // stall with four entries held
        stage_idle(); st_busy = 2'b11;
        for (int l = 0; l < 3; l++) lane(l, rpay(), 4'b0000);
        cycle();
        stage_idle(); st_busy = 2'b11; lane(0, rpay(), 4'b0000);
        cycle();
        stage_idle(); st_stall = 1'b1;
        repeat (2) cycle();
        stage_idle();
        repeat (3) cycle();

        // port 0 busy: oldest goes to port 1
        stage_idle(); st_busy = 2'b01; lane(0, rpay(), 4'b0000);
        cycle();
        stage_idle(); st_busy = 2'b01;
        repeat (2) cycle();

        // reset while full
        for (int c = 0; c < 3; c++) begin
            stage_idle(); st_busy = 2'b11;
            for (int l = 0; l < ((c == 2) ? 2 : 3); l++) lane(l, rpay(), 4'b0101);
            cycle();
        end
        stage_idle(); st_rst = 1'b1;
        for (int l = 0; l < 3; l++) lane(l, rpay(), 4'b0000);
        cycle();
        stage_idle();
        repeat (2) cycle();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            stage_idle();
            st_rst = ($urandom_range(0, 199) == 0);
            n = $urandom_range(0, N_IN);
            if ($urandom_range(0, 19) != 0 && n > m_avail()) n = m_avail();
            for (int l = 0; l < n; l++) lane(l, rpay(), 4'($urandom_range(0, 15)));
            st_busy  = 2'($urandom_range(0, 3));
            st_stall = ($urandom_range(0, 4) == 0);
            st_sq    = ($urandom_range(0, 9) == 0);
            st_sqb   = 2'($urandom_range(0, BMW-1));
            for (int k = 0; k < N_CLR; k++) begin
                st_clr[k]  = ($urandom_range(0, 3) == 0);
                st_clrb[k] = 2'($urandom_range(0, BMW-1));
            end
            cycle();
        end

        @(negedge clock);
        #1;
        mon_en = 1'b0;
        chk("issue_queue_drained", W'(exp_q.size()), '0);
        chk("status_queue_drained", W'(st_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
